// File: rtl/synth_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | synth_pkg: shared voice-state encoding and PS/2 set-2 constants   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package synth_pkg;

   localparam int NOTE_W = 7;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      V_IDLE    = 2'd0,
      V_ACTIVE  = 2'd1,
      V_RELEASE = 2'd2
   } voice_state_e;

endpackage
`default_nettype wire

// File: rtl/ps2_voice_allocator_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_voice_allocator_if: scan input, envelope status, voice outputs|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface ps2_voice_allocator_if #(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = 7
);
   logic [7:0]                   scan_data;
   logic                         scan_valid;
   logic [NUM_VOICES-1:0]        env_done;
   logic [NUM_VOICES-1:0]        voice_gate;
   logic [NUM_VOICES*NOTE_W-1:0] voice_note;
   logic [NUM_VOICES-1:0]        voice_trig;
   logic [NUM_VOICES-1:0]        voice_busy;
   logic                         steal_pulse;
   logic [4:0]                   active_count;

   modport master (
      output scan_data, scan_valid, env_done,
      input  voice_gate, voice_note, voice_trig, voice_busy, steal_pulse, active_count
   );

   modport slave (
      input  scan_data, scan_valid, env_done,
      output voice_gate, voice_note, voice_trig, voice_busy, steal_pulse, active_count
   );
endinterface
`default_nettype wire

// File: rtl/scan_to_note.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | scan_to_note: set-2 scan byte to {valid, note}, two-row piano     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module scan_to_note
   import synth_pkg::*;
#(
   parameter int NOTE_W_P = synth_pkg::NOTE_W
) (
   input  wire logic [7:0]          scan_i,
   output logic                     valid_o,
   output logic [NOTE_W_P-1:0]      note_o
);

   localparam int BASE_NOTE = 60;

   int offset;

   // Home row A..; gives white keys, the row above gives the sharps (C4 at A).
   always_comb begin
      valid_o = 1'b1;
      offset  = 0;
      case (scan_i)
         8'h1C: offset = 0;
         8'h1D: offset = 1;
         8'h1B: offset = 2;
         8'h24: offset = 3;
         8'h23: offset = 4;
         8'h2B: offset = 5;
         8'h2C: offset = 6;
         8'h34: offset = 7;
         8'h35: offset = 8;
         8'h33: offset = 9;
         8'h3C: offset = 10;
         8'h3B: offset = 11;
         8'h42: offset = 12;
         8'h44: offset = 13;
         8'h4B: offset = 14;
         8'h4D: offset = 15;
         8'h4C: offset = 16;
         default: valid_o = 1'b0;
      endcase
      note_o = NOTE_W_P'(BASE_NOTE + offset);
   end

endmodule
`default_nettype wire

// File: rtl/ps2_voice_allocator.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_voice_allocator: PS/2 scan decode and polyphonic voice alloc  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module ps2_voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = synth_pkg::NOTE_W
) (
   input  wire logic              clk,
   input  wire logic              resetn,
   ps2_voice_allocator_if.slave   bus
);
   import synth_pkg::*;

   localparam int                AGE_W   = $clog2(NUM_VOICES);
   localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(NUM_VOICES - 1);

   logic              map_valid;
   logic [NOTE_W-1:0] map_note;

   logic              ext_q;
   logic              brk_q;
   logic              ev_valid_q;
   logic              ev_on_q;
   logic [NOTE_W-1:0] ev_note_q;
   logic              steal_q;

   logic [NUM_VOICES-1:0]            is_active;
   logic [NUM_VOICES-1:0]            is_release;
   logic [NUM_VOICES-1:0]            is_idle;
   logic [NUM_VOICES-1:0]            note_hit;
   logic [NUM_VOICES-1:0]            trig_vec;
   logic [NUM_VOICES-1:0][AGE_W-1:0] ages;

   logic [NUM_VOICES-1:0] act_hit;
   logic [NUM_VOICES-1:0] rel_hit;
   logic [NUM_VOICES-1:0] alloc_sel;
   logic [NUM_VOICES-1:0] off_sel;
   logic                  alloc;
   logic                  steal;
   logic [4:0]            count;

   scan_to_note #(.NOTE_W_P(NOTE_W)) u_scan_to_note (
      .scan_i  (bus.scan_data),
      .valid_o (map_valid),
      .note_o  (map_note)
   );

   // Prefix bytes only arm flags; the next non-prefix byte closes the event.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         ev_valid_q <= 1'b0;
         ev_on_q    <= 1'b0;
         ev_note_q  <= '0;
      end else begin
         ev_valid_q <= 1'b0;
         if (bus.scan_valid) begin
            if (bus.scan_data == SC_EXT) begin
               ext_q <= 1'b1;
            end else if (bus.scan_data == SC_BREAK) begin
               brk_q <= 1'b1;
            end else begin
               ext_q      <= 1'b0;
               brk_q      <= 1'b0;
               ev_valid_q <= ~ext_q & map_valid;
               ev_on_q    <= ~brk_q;
               ev_note_q  <= map_note;
            end
         end
      end
   end

   function automatic logic [NUM_VOICES-1:0] lowest(input logic [NUM_VOICES-1:0] v);
      logic [NUM_VOICES-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (v[i] && (r == '0)) r[i] = 1'b1;
      end
      return r;
   endfunction

   // Strict '>' keeps the lowest index on equal ages.
   function automatic logic [NUM_VOICES-1:0] oldest(
      input logic [NUM_VOICES-1:0]            v,
      input logic [NUM_VOICES-1:0][AGE_W-1:0] a
   );
      logic [NUM_VOICES-1:0] r;
      logic [AGE_W-1:0]      best;
      logic                  found;
      r     = '0;
      best  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (v[i] && (!found || (a[i] > best))) begin
            r     = '0;
            r[i]  = 1'b1;
            best  = a[i];
            found = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      act_hit   = is_active & note_hit;
      rel_hit   = is_release & note_hit;
      alloc_sel = '0;
      off_sel   = '0;
      alloc     = 1'b0;
      steal     = 1'b0;
      if (ev_valid_q) begin
         if (ev_on_q) begin
            if (act_hit == '0) begin
               alloc = 1'b1;
               if (rel_hit != '0) begin
                  alloc_sel = lowest(rel_hit);
               end else if (is_idle != '0) begin
                  alloc_sel = lowest(is_idle);
               end else if (is_release != '0) begin
                  alloc_sel = oldest(is_release, ages);
               end else begin
                  alloc_sel = oldest(is_active, ages);
                  steal     = 1'b1;
               end
            end
         end else begin
            off_sel = lowest(act_hit);
         end
      end
   end

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
      voice_state_e      state_q;
      logic [NOTE_W-1:0] note_q;
      logic [AGE_W-1:0]  age_q;
      logic              trig_q;

      assign is_active[i]  = (state_q == V_ACTIVE);
      assign is_release[i] = (state_q == V_RELEASE);
      assign is_idle[i]    = (state_q == V_IDLE);
      assign note_hit[i]   = (note_q == ev_note_q);
      assign ages[i]       = age_q;
      assign trig_vec[i]   = trig_q;
      assign bus.voice_note[i*NOTE_W +: NOTE_W] = note_q;

      // A note event on this voice takes precedence over env_done.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            state_q <= V_IDLE;
            note_q  <= '0;
            age_q   <= '0;
            trig_q  <= 1'b0;
         end else begin
            trig_q <= alloc_sel[i];
            if (alloc_sel[i]) begin
               state_q <= V_ACTIVE;
               note_q  <= ev_note_q;
               age_q   <= '0;
            end else begin
               if (off_sel[i]) begin
                  state_q <= V_RELEASE;
               end else if ((state_q == V_RELEASE) && bus.env_done[i]) begin
                  state_q <= V_IDLE;
               end
               if (alloc && (state_q != V_IDLE) && (age_q != AGE_MAX)) begin
                  age_q <= age_q + AGE_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         steal_q <= 1'b0;
      end else begin
         steal_q <= steal;
      end
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         count = count + 5'(is_active[i]);
      end
   end

   assign bus.voice_gate   = is_active;
   assign bus.voice_busy   = ~is_idle;
   assign bus.voice_trig   = trig_vec;
   assign bus.steal_pulse  = steal_q;
   assign bus.active_count = count;

endmodule
`default_nettype wire

// File: doc/ps2_voice_allocator.md
# ps2_voice_allocator

Parametrised polyphonic front end that sits between `PS2_Controller` and the per-voice synthesis chain (waveform generator and envelope generator instances). It decodes raw PS/2 set-2 scan bytes, including the break (`F0`) and extended (`E0`) prefixes, into note-on and note-off events. It assigns each note to one of `NUM_VOICES` voices, with retrigger, oldest-first stealing and per-voice release tracking. It replaces the single shared key bitmap and held-note registers with independent per-voice gate and note outputs.

## Interface
- `NUM_VOICES`, 4, number of voices (2..16)
- `NOTE_W`, 7, note number width (MIDI numbering, 0..127)
- `clk` input 1: system clock (50 MHz)
- `resetn` input 1: reset, asynchronous assert, active-low
- `scan_data` input 8: scan byte from the PS/2 controller
- `scan_valid` input 1: one-cycle strobe qualifying `scan_data`
- `env_done` input NUM_VOICES: per-voice level, high when that voice's envelope has decayed to 0
- `voice_gate` output NUM_VOICES: per-voice gate, high while the key is held
- `voice_note` output NUM_VOICES*NOTE_W: note of voice i, packed at `[i*NOTE_W +: NOTE_W]`
- `voice_trig` output NUM_VOICES: one-cycle pulse on voice (re)start
- `voice_busy` output NUM_VOICES: voice is ACTIVE or RELEASE
- `steal_pulse` output 1: one-cycle pulse when an ACTIVE voice is stolen
- `active_count` output 5: number of voices in ACTIVE

## Operation
- **Prefix decoder:**
  - `E0` sets `ext_pending`.
  - `F0` sets `brk_pending`.
  - Any other byte completes the event and clears both flags.
  - If `ext_pending` was set, the event is discarded.
  - Otherwise the byte is looked up in `scan_to_note`. An unmapped code is discarded. A mapped code produces a note-off if `brk_pending` was set, else a note-on.
- **Per-voice state:**
  - States are IDLE, ACTIVE and RELEASE.
  - Each voice holds a note register and a saturating age counter (0..NUM_VOICES-1).
- **Note-on, N, in priority order:**
  1. A voice in ACTIVE with note N: no change and no trig. This absorbs typematic repeat.
  2. A voice in RELEASE with note N: that voice goes to ACTIVE, trig fires, age is set to 0.
  3. The lowest-index IDLE voice goes to ACTIVE, takes N, trig fires.
  4. The oldest RELEASE voice is reused.
  5. The oldest ACTIVE voice is stolen and `steal_pulse` fires.
  - Ties on age go to the lowest index.
  - On every allocation the chosen voice's age is set to 0. Every other busy voice increments its age, saturating.
- **Note-off, N:** a voice in ACTIVE with note N goes to RELEASE. If no voice matches, the event is ignored.
- **Release completion:** RELEASE with `env_done` high goes to IDLE. The note register is retained.
- **Simultaneous events:** if a note event and `env_done` target the same voice in the same cycle, the note event wins.
- **Output derivation:**
  - `voice_gate[i]` = state is ACTIVE.
  - `voice_busy[i]` = state is not IDLE.
  - `active_count` = popcount of `voice_gate`.

## Timing
- Event register: a byte strobed at edge T produces the registered event `ev_valid` at edge T+1.
- Voice state, note, gate and busy update at edge T+2. `voice_trig` and `steal_pulse` are high for exactly the cycle after edge T+2.
- Throughput is one byte per cycle. Back-to-back strobes are fully pipelined with no drops.
- Reset clears everything to 0: all voices IDLE, notes 0, ages 0, all outputs 0, both prefix flags 0, event pipeline empty. Reset mid-sequence (for example after `F0`) discards the pending prefix.
- `env_done` is sampled every cycle and is only acted on in RELEASE.

## Structure
- A shared package `synth_pkg` holds:
  - the voice state encoding (IDLE=0, ACTIVE=1, RELEASE=2);
  - the scan code constants `SC_BREAK=8'hF0` and `SC_EXT=8'hE0`;
  - `NOTE_W`.
- The sub-module is `scan_to_note`: a combinational map from a scan byte to `{valid, note}`, covering the two-row piano layout. It is reused by the legacy path.
- The allocator, with its priority encoders and age logic, lives in the top level as a generate loop over voices.

## Test plan
- Reset, then strobe `1C`:
  - expect voice 0 ACTIVE, note = `scan_to_note(1C)`, trig[0] pulse two cycles after the strobe, `active_count`=1;
  - then `F0 1C` moves voice 0 to RELEASE with gate low;
  - then `env_done[0]` moves voice 0 to IDLE.
- Send `1C` ×5 (typematic): expect a single trig[0] and no other voice busy.
- NUM_VOICES=4, play 5 distinct keys: expect `steal_pulse`, and the fifth note lands in voice 0 (the oldest) with trig[0].
- Release voice 1, hold the others, then play a new key with no IDLE voice: expect voice 1 reused, no steal pulse.
- Send `E0 75` then `E0 F0 75`: expect no state change. Send unmapped `7E`: no change.
- Raise `env_done[2]` in the same cycle that a note-on retriggers voice 2's note: expect voice 2 ACTIVE with trig. Assert reset mid `F0`: all outputs 0, and the next `1C` is a note-on.
